// File: rtl/segment_capture.sv
// segment_capture: reader for a multiplexed 7-segment bus. Synchronizes the
// segment lines and one-hot digit selects, waits for the combined word to
// stay unchanged for STABLE_CYCLES samples, decodes the pattern to a BCD-ish
// code and stores it per digit position. Pulses on every digit write, on
// every completed frame and on every stable window with a bad select.
module segment_capture #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  upd_valid,
  output logic [2:0]            upd_index,
  output logic                  frame_valid,
  output logic                  sel_err
);

  localparam int unsigned WW = DIGITS + 7;
  localparam int unsigned CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);

  localparam logic [3:0] CODE_BLANK = 4'hB;
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BAD   = 4'hF;

  typedef enum logic {
    SETTLE = 1'b0,
    HELD   = 1'b1
  } state_e;

  // Synchronizer stages and the last synchronized word used for change detection
  logic [WW-1:0]          word_s1_q;
  logic [WW-1:0]          word_s2_q;
  logic [WW-1:0]          word_last_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;

  state_e                 state_q;
  logic [4*DIGITS-1:0]    digits_q;
  logic [DIGITS-1:0]      digit_err_q;
  logic [DIGITS-1:0]      mask_q;
  logic                   upd_valid_q;
  logic [2:0]             upd_index_q;
  logic                   frame_valid_q;
  logic                   sel_err_q;

  logic                   changed_c;
  logic                   window_done_c;
  logic [DIGITS-1:0]      sel_c;
  logic [6:0]             seg_c;
  logic                   onehot_c;
  logic [2:0]             idx_c;
  logic [3:0]             dec_code_c;
  logic                   dec_err_c;
  logic [DIGITS-1:0]      mask_next_c;
  logic                   frame_done_c;

  // The window being qualified is the word held in word_last_q
  assign changed_c     = (word_s2_q != word_last_q);
  assign window_done_c = (cnt_q == CW'(STABLE_CYCLES));
  assign sel_c         = word_last_q[WW-1:7];
  assign seg_c         = word_last_q[6:0];
  assign onehot_c      = (sel_c != '0) && ((sel_c & (sel_c - DIGITS'(1))) == '0);
  assign mask_next_c   = mask_q | sel_c;
  assign frame_done_c  = &mask_next_c;

  // Two-flop synchronizer plus one delay stage for change detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_s1_q   <= '0;
      word_s2_q   <= '0;
      word_last_q <= '0;
      cnt_q       <= '0;
    end else begin
      word_s1_q   <= {dig_sel, seg_in};
      word_s2_q   <= word_s1_q;
      word_last_q <= word_s2_q;
      cnt_q       <= cnt_d;
    end
  end

  // Stability counter: reload on change, otherwise count up and saturate
  always_comb begin
    cnt_d = cnt_q;
    if (changed_c) begin
      cnt_d = CW'(1);
    end else if (!window_done_c) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // One-hot select to binary index
  always_comb begin
    idx_c = 3'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sel_c[i]) begin
        idx_c = 3'(i);
      end
    end
  end

  // Segment pattern decode {a,b,c,d,e,f,g}
  always_comb begin
    dec_err_c = 1'b0;
    case (seg_c)
      7'b1111110: dec_code_c = 4'h0;
      7'b0110000: dec_code_c = 4'h1;
      7'b1101101: dec_code_c = 4'h2;
      7'b1111001: dec_code_c = 4'h3;
      7'b0110011: dec_code_c = 4'h4;
      7'b1011011: dec_code_c = 4'h5;
      7'b1011111: dec_code_c = 4'h6;
      7'b1110000: dec_code_c = 4'h7;
      7'b1111111: dec_code_c = 4'h8;
      7'b1111011: dec_code_c = 4'h9;
      7'b0000001: dec_code_c = CODE_DASH;
      7'b0000000: dec_code_c = CODE_BLANK;
      default: begin
        dec_code_c = CODE_BAD;
        dec_err_c  = 1'b1;
      end
    endcase
  end

  // Capture FSM: one capture (or select error) per stable window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= SETTLE;
      digits_q      <= {DIGITS{CODE_BLANK}};
      digit_err_q   <= '0;
      mask_q        <= '0;
      upd_valid_q   <= 1'b0;
      upd_index_q   <= 3'd0;
      frame_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      upd_valid_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
      case (state_q)
        SETTLE: begin
          if (window_done_c) begin
            if (onehot_c) begin
              for (int unsigned i = 0; i < DIGITS; i++) begin
                if (sel_c[i]) begin
                  digits_q[4*i +: 4] <= dec_code_c;
                  digit_err_q[i]     <= dec_err_c;
                end
              end
              upd_valid_q <= 1'b1;
              upd_index_q <= idx_c;
              if (frame_done_c) begin
                frame_valid_q <= 1'b1;
                mask_q        <= '0;
              end else begin
                mask_q <= mask_next_c;
              end
            end else begin
              sel_err_q <= 1'b1;
            end
            // A change landing on the capture edge opens a new window at once
            state_q <= changed_c ? SETTLE : HELD;
          end
        end
        HELD: begin
          if (changed_c) begin
            state_q <= SETTLE;
          end
        end
        default: state_q <= SETTLE;
      endcase
    end
  end

  assign digits      = digits_q;
  assign digit_err   = digit_err_q;
  assign upd_valid   = upd_valid_q;
  assign upd_index   = upd_index_q;
  assign frame_valid = frame_valid_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_segment_capture.sv
// Testbench for segment_capture: directed scenarios plus random scanning,
// checked every cycle against a run-length based reference model.
module tb_segment_capture;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned S      = 4;

  logic        clk;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        upd_valid;
  logic [2:0]  upd_index;
  logic        frame_valid;
  logic        sel_err;

  segment_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .digits      (digits),
    .digit_err   (digit_err),
    .upd_valid   (upd_valid),
    .upd_index   (upd_index),
    .frame_valid (frame_valid),
    .sel_err     (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: input history, run length of the synchronized stream
  logic [10:0] h1, h2, prev_s;
  int          prev_run;
  logic [15:0] m_digits;
  logic [3:0]  m_err, m_mask;
  logic        e_upd, e_frame, e_selerr;
  logic [2:0]  e_idx;

  // Observed pulse bookkeeping for directed checks
  int n_upd, n_frame, n_selerr, n_steps, first_upd_step, frame_at_upd;

  logic [6:0] pats [12];

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: return 5'h00;
      7'b0110000: return 5'h01;
      7'b1101101: return 5'h02;
      7'b1111001: return 5'h03;
      7'b0110011: return 5'h04;
      7'b1011011: return 5'h05;
      7'b1011111: return 5'h06;
      7'b1110000: return 5'h07;
      7'b1111111: return 5'h08;
      7'b1111011: return 5'h09;
      7'b0000001: return 5'h0A;
      7'b0000000: return 5'h0B;
      default:    return 5'h1F;
    endcase
  endfunction

  task automatic model_reset();
    h1 = '0; h2 = '0; prev_s = '0; prev_run = 0;
    m_digits = 16'hBBBB; m_err = '0; m_mask = '0;
    e_upd = 0; e_frame = 0; e_selerr = 0; e_idx = '0;
  endtask

  // One clock edge: input in_now is the value present at that edge
  task automatic model_edge(input logic [10:0] in_now);
    logic [10:0] s;
    logic [3:0]  sel;
    logic [4:0]  d;
    int          idx;
    s  = h2;
    h2 = h1;
    h1 = in_now;
    e_upd = 0; e_frame = 0; e_selerr = 0;
    if (prev_run == S) begin
      sel = prev_s[10:7];
      if ($countones(sel) == 1) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
        d = decode(prev_s[6:0]);
        m_digits[4*idx +: 4] = d[3:0];
        m_err[idx] = d[4];
        e_upd = 1;
        e_idx = 3'(idx);
        m_mask[idx] = 1'b1;
        if (m_mask == 4'hF) begin
          e_frame = 1;
          m_mask = '0;
        end
      end else begin
        e_selerr = 1;
      end
    end
    prev_run = (s != prev_s) ? 1 : ((prev_run < 1000) ? prev_run + 1 : prev_run);
    prev_s = s;
  endtask

  task automatic compare_all();
    check("digits", 32'(digits), 32'(m_digits));
    check("digit_err", 32'(digit_err), 32'(m_err));
    check("upd_valid", 32'(upd_valid), 32'(e_upd));
    if (e_upd) check("upd_index", 32'(upd_index), 32'(e_idx));
    check("frame_valid", 32'(frame_valid), 32'(e_frame));
    check("sel_err", 32'(sel_err), 32'(e_selerr));
  endtask

  task automatic step(input logic [3:0] sel, input logic [6:0] seg);
    dig_sel = sel;
    seg_in  = seg;
    @(posedge clk);
    model_edge({sel, seg});
    #1;
    compare_all();
    n_steps++;
    if (upd_valid) begin
      n_upd++;
      if (first_upd_step < 0) first_upd_step = n_steps;
    end
    if (frame_valid) begin
      n_frame++;
      frame_at_upd = n_upd;
    end
    if (sel_err) n_selerr++;
  endtask

  task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) step(sel, seg);
  endtask

  // Assert reset between edges, keep it across one edge, release between edges
  task automatic do_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_digits", 32'(digits), 32'h0000_BBBB);
    check("rst_flags", {26'd0, digit_err, upd_valid, frame_valid}, 32'd0);
    check("rst_pulses", {29'd0, sel_err, upd_index[1:0]}, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  task automatic clear_counts();
    n_upd = 0; n_frame = 0; n_selerr = 0; n_steps = 0;
    first_upd_step = -1; frame_at_upd = -1;
  endtask

  initial begin
    int base_upd, base_sel;
    logic [15:0] snap;
    pats[0] = 7'b1111110; pats[1] = 7'b0110000; pats[2]  = 7'b1101101;
    pats[3] = 7'b1111001; pats[4] = 7'b0110011; pats[5]  = 7'b1011011;
    pats[6] = 7'b1011111; pats[7] = 7'b1110000; pats[8]  = 7'b1111111;
    pats[9] = 7'b1111011; pats[10] = 7'b0000001; pats[11] = 7'b0000000;

    rst = 1'b1; seg_in = '0; dig_sel = '0;
    model_reset();
    clear_counts();
    @(posedge clk);
    #1;

    // Reset with idle bus: one select error after the window
    do_reset();
    clear_counts();
    hold(4'b0000, 7'b0000000, 10);
    check("idle_selerr_count", 32'(n_selerr), 32'd1);

    // Latency: pulse on the (S+3)th step, i.e. edge N+S+2
    clear_counts();
    hold(4'b0001, 7'b1111001, 14);
    check("lat_first_step", 32'(first_upd_step), 32'(S + 3));
    check("lat_upd_count", 32'(n_upd), 32'd1);
    check("lat_digit0", 32'(digits[3:0]), 32'h3);

    // Glitch inside the window restarts it; only the final value is captured
    clear_counts();
    hold(4'b0010, 7'b1111001, 2);
    hold(4'b0010, 7'b0110000, 2);
    hold(4'b0010, 7'b1111001, 12);
    check("glitch_upd_count", 32'(n_upd), 32'd1);
    check("glitch_digit1", 32'(digits[7:4]), 32'h3);

    // Full frame 7,0,dash,5 from a clean reset
    do_reset();
    clear_counts();
    hold(4'b1000, 7'b1110000, 10);
    hold(4'b0100, 7'b1111110, 10);
    hold(4'b0010, 7'b0000001, 10);
    hold(4'b0001, 7'b1011011, 10);
    check("frame_upd_count", 32'(n_upd), 32'd4);
    check("frame_count", 32'(n_frame), 32'd1);
    check("frame_on_4th", 32'(frame_at_upd), 32'd4);
    check("frame_digits", 32'(digits), 32'h0000_70A5);
    check("frame_err", 32'(digit_err), 32'd0);

    // Unknown pattern, then multi-hot select
    hold(4'b0100, 7'b1000000, 10);
    check("bad_digit2", 32'(digits[11:8]), 32'hF);
    check("bad_err2", 32'(digit_err[2]), 32'd1);
    snap = digits;
    base_upd = n_upd;
    base_sel = n_selerr;
    hold(4'b0011, 7'b1111110, 10);
    check("multihot_selerr", 32'(n_selerr - base_sel), 32'd1);
    check("multihot_no_upd", 32'(n_upd - base_upd), 32'd0);
    check("multihot_digits", 32'(digits), 32'(snap));

    // Reset mid-frame, then a fresh frame completes on the 4th new capture
    do_reset();
    hold(4'b0001, 7'b0110011, 8);
    hold(4'b0010, 7'b1011111, 8);
    hold(4'b0100, 7'b1011111, 3);
    do_reset();
    check("midreset_digits", 32'(digits), 32'h0000_BBBB);
    clear_counts();
    hold(4'b0001, 7'b1101101, 8);
    hold(4'b0010, 7'b1111111, 8);
    hold(4'b0100, 7'b1111011, 8);
    hold(4'b1000, 7'b0110000, 8);
    check("refresh_frame_count", 32'(n_frame), 32'd1);
    check("refresh_frame_on_4th", 32'(frame_at_upd), 32'd4);
    check("refresh_digits", 32'(digits), 32'h0000_1982);

    // Random scanning with occasional resets, checked by the model every cycle
    for (int t = 0; t < 400; t++) begin
      int r;
      logic [3:0] sel;
      logic [6:0] seg;
      r = int'($urandom_range(0, 11));
      if (r < 8)       sel = 4'(1 << (r % 4));
      else if (r < 10) sel = 4'($urandom_range(0, 15));
      else             sel = '0;
      if ($urandom_range(0, 9) < 8) seg = pats[$urandom_range(0, 11)];
      else                          seg = 7'($urandom_range(0, 127));
      hold(sel, seg, int'($urandom_range(1, 9)));
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/segment_capture.md
Name: segment_capture

Overview:
- Reader side of the BCD 7-segment display interface: observes a multiplexed 7-segment bus (segment lines plus one-hot digit selects) and recovers one BCD code per digit position.
- Sits between an external or looped-back display drive and the self-check / readback logic, so driven displays can be verified digit by digit.
- Samples asynchronous inputs, qualifies each pattern as stable over a programmable window, decodes it and stores the result per digit.
- Signals each digit update and each completed frame.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- seg_in  input  7  segment lines, seg_in[6:0] = a,b,c,d,e,f,g, active-high, asynchronous.
- dig_sel  input  DIGITS  digit select, active-high, one-hot when valid, asynchronous.
- digits  output  4*DIGITS  captured codes; digit i at [4i+3:4i].
- digit_err  output  DIGITS  bit i set when digit i's last capture was an unknown pattern.
- upd_valid  output  1  one-cycle pulse when a digit register is written.
- upd_index  output  3  index of the digit written; valid only with upd_valid.
- frame_valid  output  1  one-cycle pulse when every digit has been captured since the previous frame_valid or reset.
- sel_err  output  1  one-cycle pulse when a stable window completes with dig_sel zero or multi-hot.

Behaviour:
- Reset (rst low, asynchronous):
  - digits = all 4'hB.
  - digit_err = 0; upd_valid = 0; upd_index = 0; frame_valid = 0; sel_err = 0.
  - Synchronizers cleared; stability counter = 0; frame-seen mask = 0; FSM = SETTLE.
- Input path: seg_in and dig_sel pass through a 2-flop synchronizer. Stability is judged on the synchronized word {dig_sel, seg_in}.
- Stability counter:
  - Reloads to 1 on any change of the synchronized word.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM:
  - SETTLE:
    - Counter reaches STABLE_CYCLES with dig_sel one-hot: write the digit, pulse upd_valid, go to HELD.
    - Counter reaches STABLE_CYCLES with dig_sel not one-hot: pulse sel_err, go to HELD, no write.
  - HELD:
    - No further captures or pulses while the word is unchanged.
    - Any change of the word: go to SETTLE, counter = 1.
- Latency: inputs held from sampling edge N produce digits, upd_valid and upd_index at edge N+STABLE_CYCLES+2. A change at any point inside the window restarts it.
- Decode map (pattern -> code, err):
  - 1111110 -> 0
  - 0110000 -> 1
  - 1101101 -> 2
  - 1111001 -> 3
  - 0110011 -> 4
  - 1011011 -> 5
  - 1011111 -> 6
  - 1110000 -> 7
  - 1111111 -> 8
  - 1111011 -> 9
  - 0000001 -> A (dash), err 0
  - 0000000 -> B (blank), err 0
  - anything else -> F, err 1
  - digit_err[i] is rewritten on every capture of digit i.
- Frame tracking:
  - Each write sets mask bit i.
  - When the mask becomes all-ones, frame_valid pulses in the same cycle as the completing upd_valid, and the mask clears in that cycle.
  - Recapturing an already-set digit leaves the mask unchanged.
- Same digit and same pattern reappearing after any change are captured again, with a new upd_valid.
- dig_sel index >= DIGITS is impossible by width. upd_index upper bits are 0 when DIGITS < 8.
- Reset asserted mid-window or mid-frame: all state is discarded and no pulse is emitted. Counting restarts from the first edge after rst deasserts.
- STABLE_CYCLES = 1: a word is captured after a single synchronized sample.

Test Plan:
- Reset: rst low, then high with all inputs 0 -> digits = 16'hBBBB; all flags and pulses 0; after 6 cycles sel_err pulses once (dig_sel = 0).
- Latency: dig_sel=4'b0001, seg_in=7'b1111001 held from edge N -> upd_valid=1, upd_index=0, digits[3:0]=4'h3 exactly at edge N+6; no second pulse while held.
- Glitch rejection: seg_in toggles to 7'b0110000 for 2 cycles then back, during the window -> window restarts; only one capture, of the final stable value.
- Scan a full frame: digits 3..0 showing 7,0,dash,5, each held 10 cycles -> 4 upd_valid pulses; frame_valid coincides with the 4th; digits=16'h70A5; digit_err=0.
- Bad pattern and select: digit 2 with seg_in=7'b1000000 -> digits[11:8]=F, digit_err[2]=1. Later, dig_sel=4'b0011 stable -> sel_err pulse, no upd_valid, digits unchanged.
- Reset mid-frame: after 2 of 4 digits are captured, pulse rst low -> digits back to 16'hBBBB. A fresh 4-digit scan then gives frame_valid only on the 4th new capture.
